pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 57 +++++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: instruction entry tag, hazard-unit stall/flush
// requests, and the enables, stage-valid flags, release port and counters
// returned by the pipeline controller.
interface pipe_ctrl_if;
  logic        in_valid;
  logic        in_we;
  logic [4:0]  in_rd;

  logic        stall_F;
  logic        stall_D;
  logic        stall_E;
  logic        stall_M;
  logic        stall_WB;

  logic        flush_D;
  logic        flush_E;
  logic        flush_M;
  logic        flush_WB;

  logic        en_F;
  logic        en_D;
  logic        en_E;
  logic        en_M;
  logic        en_WB;

  logic        valid_D;
  logic        valid_E;
  logic        valid_M;
  logic        valid_WB;

  logic        rel_valid;
  logic [4:0]  rel_rd;
  logic [31:0] retired_cnt;
  logic [15:0] bubble_cnt;
  logic        pipe_empty;
  logic        err_stall;

  // Hazard unit / instruction source side
  modport master (
    output in_valid, in_we, in_rd,
    output stall_F, stall_D, stall_E, stall_M, stall_WB,
    output flush_D, flush_E, flush_M, flush_WB,
    input  en_F, en_D, en_E, en_M, en_WB,
    input  valid_D, valid_E, valid_M, valid_WB,
    input  rel_valid, rel_rd, retired_cnt, bubble_cnt, pipe_empty, err_stall
  );

  // Pipeline controller side
  modport slave (
    input  in_valid, in_we, in_rd,
    input  stall_F, stall_D, stall_E, stall_M, stall_WB,
    input  flush_D, flush_E, flush_M, flush_WB,
    output en_F, en_D, en_E, en_M, en_WB,
    output valid_D, valid_E, valid_M, valid_WB,
    output rel_valid, rel_rd, retired_cnt, bubble_cnt, pipe_empty, err_stall
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: tracks a {valid, we, rd} tag through the D, E, M and
// WB stages under hazard-unit stall/flush control, releases destination
// register reservations as instructions retire, counts retired instructions
// and drained bubbles, and flags non-contiguous stall requests.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
  } tag_t;

  localparam tag_t BUBBLE = '0;

  tag_t        tag_f;
  tag_t        tag_d;
  tag_t        tag_e;
  tag_t        tag_m;
  tag_t        tag_wb;
  logic        retire;
  logic        violation;
  logic [31:0] retired_q;
  logic [15:0] bubble_q;
  logic        err_q;

  // Next value of one stage: a flush wins over a stall, a held stage keeps
  // its tag, and a stalled predecessor hands over a bubble instead of its tag.
  function automatic tag_t next_tag(input tag_t cur, input tag_t prev,
                                    input logic flush, input logic stall,
                                    input logic prev_stall);
    tag_t res;
    if (flush)
      res = BUBBLE;
    else if (stall)
      res = cur;
    else if (prev_stall)
      res = BUBBLE;
    else
      res = prev;
    return res;
  endfunction

  assign tag_f = {bus.in_valid, bus.in_we, bus.in_rd};

  // A stall is legal only when every earlier stage is stalled as well.
  assign violation =
      (bus.stall_D  & ~bus.stall_F) |
      (bus.stall_E  & ~(bus.stall_F & bus.stall_D)) |
      (bus.stall_M  & ~(bus.stall_F & bus.stall_D & bus.stall_E)) |
      (bus.stall_WB & ~(bus.stall_F & bus.stall_D & bus.stall_E & bus.stall_M));

  assign retire = tag_wb.valid & ~bus.stall_WB & ~bus.flush_WB;

  // Advance the stage tags; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_d  <= BUBBLE;
      tag_e  <= BUBBLE;
      tag_m  <= BUBBLE;
      tag_wb <= BUBBLE;
    end else begin
      tag_d  <= next_tag(tag_d,  tag_f, bus.flush_D,  bus.stall_D,  bus.stall_F);
      tag_e  <= next_tag(tag_e,  tag_d, bus.flush_E,  bus.stall_E,  bus.stall_D);
      tag_m  <= next_tag(tag_m,  tag_e, bus.flush_M,  bus.stall_M,  bus.stall_E);
      tag_wb <= next_tag(tag_wb, tag_m, bus.flush_WB, bus.stall_WB, bus.stall_M);
    end
  end

  // Retired-instruction counter, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retired_q <= '0;
    else if (retire)
      retired_q <= retired_q + 32'd1;
  end

  // Bubble counter: an empty, unstalled WB drains one bubble; saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bubble_q <= '0;
    else if (!tag_wb.valid && !bus.stall_WB && (bubble_q != 16'hFFFF))
      bubble_q <= bubble_q + 16'd1;
  end

  // Sticky stall-protocol error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if (violation)
      err_q <= 1'b1;
  end

  assign bus.en_F  = ~bus.stall_F;
  assign bus.en_D  = ~bus.stall_D;
  assign bus.en_E  = ~bus.stall_E;
  assign bus.en_M  = ~bus.stall_M;
  assign bus.en_WB = ~bus.stall_WB;

  assign bus.valid_D  = tag_d.valid;
  assign bus.valid_E  = tag_e.valid;
  assign bus.valid_M  = tag_m.valid;
  assign bus.valid_WB = tag_wb.valid;

  assign bus.rel_valid = retire & tag_wb.we & (tag_wb.rd != 5'd0);
  assign bus.rel_rd    = bus.rel_valid ? tag_wb.rd : 5'd0;

  assign bus.pipe_empty  = ~(tag_d.valid | tag_e.valid | tag_m.valid | tag_wb.valid);
  assign bus.retired_cnt = retired_q;
  assign bus.bubble_cnt  = bubble_q;
  assign bus.err_stall   = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with hand-derived
// expectations plus a randomized run against a behavioural pipeline model.
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0..3 = D, E, M, WB
  typedef struct packed {
    bit       v;
    bit       we;
    bit [4:0] rd;
  } mtag_t;

  mtag_t     m_tag [4];
  bit [31:0] m_retired;
  int        m_bubble;
  bit        m_err;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_tag[k] = '0;
    m_retired = '0;
    m_bubble  = 0;
    m_err     = 1'b0;
  endtask

  task automatic model_edge();
    mtag_t    nxt [4];
    mtag_t    prev;
    bit [4:0] s;
    bit [3:0] f;
    bit       viol;
    s = {bus.stall_WB, bus.stall_M, bus.stall_E, bus.stall_D, bus.stall_F};
    f = {bus.flush_WB, bus.flush_M, bus.flush_E, bus.flush_D};
    viol = 1'b0;
    for (int i = 1; i < 5; i++)
      for (int j = 0; j < i; j++)
        if (s[i] && !s[j]) viol = 1'b1;
    if (m_tag[3].v && !s[4] && !f[3]) m_retired = m_retired + 32'd1;
    if (!m_tag[3].v && !s[4] && m_bubble < 65535) m_bubble = m_bubble + 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) prev = {bus.in_valid, bus.in_we, bus.in_rd};
      else        prev = m_tag[k-1];
      if (f[k])          nxt[k] = '0;
      else if (s[k+1])   nxt[k] = m_tag[k];
      else if (s[k])     nxt[k] = '0;
      else               nxt[k] = prev;
    end
    m_tag = nxt;
    m_err = m_err | viol;
  endtask

  function automatic bit exp_rel();
    return m_tag[3].v && m_tag[3].we && (m_tag[3].rd != 5'd0) &&
           !bus.stall_WB && !bus.flush_WB;
  endfunction

  function automatic bit [3:0] dut_valid();
    return {bus.valid_WB, bus.valid_M, bus.valid_E, bus.valid_D};
  endfunction

  function automatic bit [4:0] dut_en();
    return {bus.en_WB, bus.en_M, bus.en_E, bus.en_D, bus.en_F};
  endfunction

  task automatic drive_in(input bit v, input bit we, input bit [4:0] rd);
    bus.in_valid = v;
    bus.in_we    = we;
    bus.in_rd    = rd;
  endtask

  // st: bit0=F .. bit4=WB ; fl: bit0=D .. bit3=WB
  task automatic drive_ctl(input bit [4:0] st, input bit [3:0] fl);
    bus.stall_F  = st[0];
    bus.stall_D  = st[1];
    bus.stall_E  = st[2];
    bus.stall_M  = st[3];
    bus.stall_WB = st[4];
    bus.flush_D  = fl[0];
    bus.flush_E  = fl[1];
    bus.flush_M  = fl[2];
    bus.flush_WB = fl[3];
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_clear();
    else        model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_in(0, 0, 0);
    drive_ctl(0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    drive_in(1, 1, 3);
    drive_ctl(5'b10101, 0);
    #2;
    checks++;
    if (dut_valid() !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", dut_valid());
    end
    checks++;
    if (bus.pipe_empty !== 1'b1) begin
      errors++; $display("FAIL reset_empty: got %b expected 1", bus.pipe_empty);
    end
    checks++;
    if (bus.rel_valid !== 1'b0 || bus.rel_rd !== 5'd0) begin
      errors++; $display("FAIL reset_rel: got %b/%0d expected 0/0", bus.rel_valid, bus.rel_rd);
    end
    checks++;
    if (dut_en() !== 5'b01010) begin
      errors++; $display("FAIL reset_en: got %b expected 01010", dut_en());
    end
    step();
    checks++;
    if (bus.retired_cnt !== 32'd0 || bus.bubble_cnt !== 16'd0 || bus.err_stall !== 1'b0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%b expected 0/0/0",
                         bus.retired_cnt, bus.bubble_cnt, bus.err_stall);
    end
    checks++;
    if (dut_valid() !== 4'b0000) begin
      errors++; $display("FAIL reset_hold_valid: got %b expected 0000", dut_valid());
    end
  endtask

  task automatic test_basic_flow();
    do_reset();
    drive_in(1, 1, 5);
    step();
    drive_in(0, 0, 0);
    step();
    step();
    checks++;
    if (bus.valid_M !== 1'b1 || bus.valid_WB !== 1'b0) begin
      errors++; $display("FAIL basic_in_m: got M=%b WB=%b expected M=1 WB=0", bus.valid_M, bus.valid_WB);
    end
    step();
    checks++;
    if (bus.valid_WB !== 1'b1) begin
      errors++; $display("FAIL basic_valid_wb: got %b expected 1", bus.valid_WB);
    end
    checks++;
    if (bus.rel_valid !== 1'b1 || bus.rel_rd !== 5'd5) begin
      errors++; $display("FAIL basic_release: got %b/%0d expected 1/5", bus.rel_valid, bus.rel_rd);
    end
    checks++;
    if (bus.retired_cnt !== 32'd0) begin
      errors++; $display("FAIL basic_retired_before: got %0d expected 0", bus.retired_cnt);
    end
    step();
    checks++;
    if (bus.retired_cnt !== 32'd1 || bus.rel_valid !== 1'b0) begin
      errors++; $display("FAIL basic_retired_after: got %0d/%b expected 1/0", bus.retired_cnt, bus.rel_valid);
    end
  endtask

  task automatic test_stall_bubbles();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive_in(1, 1, 5'(c + 1));
      step();
    end
    checks++;
    if (bus.bubble_cnt !== 16'd4) begin
      errors++; $display("FAIL bub_fill: got %0d expected 4", bus.bubble_cnt);
    end
    drive_ctl(5'b00011, 0);
    step();
    checks++;
    if (bus.valid_E !== 1'b0 || bus.valid_M !== 1'b1) begin
      errors++; $display("FAIL bub_first: got E=%b M=%b expected E=0 M=1", bus.valid_E, bus.valid_M);
    end
    step();
    checks++;
    if (bus.valid_E !== 1'b0 || bus.valid_M !== 1'b0 || bus.valid_WB !== 1'b1) begin
      errors++; $display("FAIL bub_second: got E=%b M=%b WB=%b expected 0 0 1",
                         bus.valid_E, bus.valid_M, bus.valid_WB);
    end
    drive_ctl(0, 0);
    #1;
    checks++;
    if (bus.rel_valid !== 1'b1 || bus.rel_rd !== 5'd7) begin
      errors++; $display("FAIL bub_rd7_in_wb: got %b/%0d expected 1/7", bus.rel_valid, bus.rel_rd);
    end
    step();
    checks++;
    if (bus.bubble_cnt !== 16'd4 || bus.valid_WB !== 1'b0) begin
      errors++; $display("FAIL bub_pre_drain: got %0d/%b expected 4/0", bus.bubble_cnt, bus.valid_WB);
    end
    step();
    step();
    checks++;
    if (bus.bubble_cnt !== 16'd6) begin
      errors++; $display("FAIL bub_drained: got %0d expected 6", bus.bubble_cnt);
    end
    step();
    checks++;
    if (bus.bubble_cnt !== 16'd6) begin
      errors++; $display("FAIL bub_stable: got %0d expected 6", bus.bubble_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive_in(1, 1, 10); step();
    drive_in(1, 0, 6);  step();
    drive_in(1, 1, 4);  step();
    drive_in(1, 1, 3);  step();
    checks++;
    if (dut_valid() !== 4'b1111) begin
      errors++; $display("FAIL flush_filled: got %b expected 1111", dut_valid());
    end
    drive_in(0, 0, 0);
    drive_ctl(0, 4'b0111);
    #1;
    checks++;
    if (bus.rel_valid !== 1'b1 || bus.rel_rd !== 5'd10) begin
      errors++; $display("FAIL flush_wb_retires: got %b/%0d expected 1/10", bus.rel_valid, bus.rel_rd);
    end
    step();
    drive_ctl(0, 0);
    // M's tag still advances into WB on the flushing edge; D and E are lost
    checks++;
    if (dut_valid() !== 4'b1000) begin
      errors++; $display("FAIL flush_stages: got %b expected 1000", dut_valid());
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (bus.rel_valid !== 1'b0) begin
        errors++; $display("FAIL flush_no_release: got rel_valid=1 rd=%0d expected 0", bus.rel_rd);
      end
      step();
    end
    checks++;
    if (bus.retired_cnt !== 32'd2) begin
      errors++; $display("FAIL flush_retired: got %0d expected 2", bus.retired_cnt);
    end
  endtask

  task automatic test_wb_stall();
    int pulses;
    do_reset();
    drive_in(1, 1, 9); step();
    drive_in(0, 0, 0);
    repeat (3) step();
    for (int c = 0; c < 3; c++) begin
      drive_ctl(5'b11111, 0);
      #1;
      checks++;
      if (bus.rel_valid !== 1'b0 || bus.rel_rd !== 5'd0) begin
        errors++; $display("FAIL wbstall_held_rel: got %b/%0d expected 0/0", bus.rel_valid, bus.rel_rd);
      end
      step();
      checks++;
      if (bus.valid_WB !== 1'b1) begin
        errors++; $display("FAIL wbstall_held_valid: got %b expected 1", bus.valid_WB);
      end
    end
    drive_ctl(0, 0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.rel_valid === 1'b1) begin
        pulses++;
        checks++;
        if (bus.rel_rd !== 5'd9) begin
          errors++; $display("FAIL wbstall_rd: got %0d expected 9", bus.rel_rd);
        end
      end
      step();
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL wbstall_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (bus.retired_cnt !== 32'd1 || bus.err_stall !== 1'b0) begin
      errors++; $display("FAIL wbstall_retired: got %0d/%b expected 1/0", bus.retired_cnt, bus.err_stall);
    end
  endtask

  task automatic test_stall_error();
    do_reset();
    drive_ctl(5'b00100, 0);
    #1;
    checks++;
    if (bus.err_stall !== 1'b0) begin
      errors++; $display("FAIL err_before: got %b expected 0", bus.err_stall);
    end
    step();
    checks++;
    if (bus.err_stall !== 1'b1) begin
      errors++; $display("FAIL err_set: got %b expected 1", bus.err_stall);
    end
    drive_ctl(0, 0);
    repeat (3) step();
    checks++;
    if (bus.err_stall !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_stall);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.err_stall !== 1'b0) begin
      errors++; $display("FAIL err_cleared: got %b expected 0", bus.err_stall);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive_in(1, 1, 5'(c + 1));
      step();
    end
    checks++;
    if (dut_valid() !== 4'b1111 || bus.retired_cnt !== 32'd1) begin
      errors++; $display("FAIL midrst_filled: got %b/%0d expected 1111/1", dut_valid(), bus.retired_cnt);
    end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (dut_valid() !== 4'b0000 || bus.pipe_empty !== 1'b1) begin
      errors++; $display("FAIL midrst_valid: got %b/%b expected 0000/1", dut_valid(), bus.pipe_empty);
    end
    checks++;
    if (bus.retired_cnt !== 32'd0 || bus.bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_counters: got %0d/%0d expected 0/0", bus.retired_cnt, bus.bubble_cnt);
    end
    checks++;
    if (bus.rel_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_rel: got %b expected 0", bus.rel_valid);
    end
    step();
    checks++;
    if (bus.rel_valid !== 1'b0 || dut_valid() !== 4'b0000) begin
      errors++; $display("FAIL midrst_hold: got %b/%b expected 0/0000", bus.rel_valid, dut_valid());
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (dut_valid() !== 4'b0001) begin
      errors++; $display("FAIL midrst_first_edge: got %b expected 0001", dut_valid());
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive_in(1, 1, 0); step();
    drive_in(0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (bus.rel_valid !== 1'b0) begin
        errors++; $display("FAIL rd0_no_release: got %b expected 0", bus.rel_valid);
      end
      step();
    end
    checks++;
    if (bus.retired_cnt !== 32'd1) begin
      errors++; $display("FAIL rd0_retired: got %0d expected 1", bus.retired_cnt);
    end
  endtask

  task automatic test_random();
    bit [4:0] st;
    bit [3:0] fl;
    bit       er;
    bit [4:0] erd;
    int       r;
    int       depth;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (i >= 250 && r == 0)
        st = 5'($urandom_range(1, 31));
      else if (r < 14)
        st = '0;
      else begin
        depth = $urandom_range(1, 5);
        st = 5'((1 << depth) - 1);
      end
      for (int k = 0; k < 4; k++) fl[k] = ($urandom_range(0, 15) == 0);
      drive_ctl(st, fl);
      drive_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      #1;
      er  = exp_rel();
      erd = er ? m_tag[3].rd : 5'd0;
      checks++;
      if (dut_en() !== ~st) begin
        errors++; $display("FAIL rnd_en cycle %0d: got %b expected %b", i, dut_en(), ~st);
      end
      checks++;
      if (bus.rel_valid !== er || bus.rel_rd !== erd) begin
        errors++; $display("FAIL rnd_release cycle %0d: got %b/%0d expected %b/%0d",
                           i, bus.rel_valid, bus.rel_rd, er, erd);
      end
      step();
      checks++;
      if (dut_valid() !== {m_tag[3].v, m_tag[2].v, m_tag[1].v, m_tag[0].v} ||
          bus.pipe_empty !== !(m_tag[0].v || m_tag[1].v || m_tag[2].v || m_tag[3].v)) begin
        errors++; $display("FAIL rnd_valid cycle %0d: got %b/%b expected %b", i, dut_valid(),
                           bus.pipe_empty, {m_tag[3].v, m_tag[2].v, m_tag[1].v, m_tag[0].v});
      end
      checks++;
      if (bus.retired_cnt !== m_retired || bus.bubble_cnt !== m_bubble[15:0] ||
          bus.err_stall !== m_err) begin
        errors++; $display("FAIL rnd_counters cycle %0d: got %0d/%0d/%b expected %0d/%0d/%b", i,
                           bus.retired_cnt, bus.bubble_cnt, bus.err_stall, m_retired, m_bubble, m_err);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_flow();
    test_stall_bubbles();
    test_flush();
    test_wb_stall();
    test_stall_error();
    test_mid_reset();
    test_rd_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
